// File: rtl/ubi_stream_acc_pkg.sv
// Shared definitions for the unary stream accumulator: FSM state encoding and the
// bipolar offset helper used to centre the ones count around zero.
package ubi_stream_acc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } acc_state_e;

  // Half-window offset, 2^(bitwidth-1), subtracted from the ones count.
  function automatic int unsigned acc_offset(input int unsigned bitwidth);
    return 32'd1 << (bitwidth - 1);
  endfunction

endpackage

// File: rtl/ubi_win_cnt.sv
// Window sample counter: BITWIDTH-bit up-counter with synchronous clear and enable;
// oLast flags the final sample (count == 2^BITWIDTH - 1).
module ubi_win_cnt #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic iClk,
  input  logic iRstN,
  input  logic iClr,
  input  logic iEn,
  output logic oLast
);

  logic [BITWIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (iClr) begin
      count_d = '0;
    end else if (iEn) begin
      // Wraps to zero after the last sample of the window.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign oLast = &count_q;

endmodule

// File: rtl/ubi_stream_acc.sv
// Unary bipolar stream accumulator: counts ones over a 2^BITWIDTH sample window and
// presents (ones - 2^(BITWIDTH-1)) on a valid/ready output. Optional UBI_ACC_AUTORESTART_EN
// makes every accepted result immediately start the next window.
module ubi_stream_acc
  import ubi_stream_acc_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iStart,
  input  logic              iBit,
  input  logic              iReady,
  output logic              oBusy,
  output logic              oValid,
  output logic [BITWIDTH:0] oData
);

  localparam int unsigned       OffsetInt = acc_offset(BITWIDTH);
  localparam logic [BITWIDTH:0] Offset    = OffsetInt[BITWIDTH:0];

  acc_state_e        state_q, state_d;
  logic [BITWIDTH:0] ones_q, ones_d, ones_sum;
  logic [BITWIDTH:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q;
  logic              win_clr, win_en, win_last;
  logic              restart;

`ifdef UBI_ACC_AUTORESTART_EN
  assign restart = iEn;
`else
  assign restart = iEn & iStart;
`endif

  assign ones_sum = ones_q + {{BITWIDTH{1'b0}}, iBit};

  ubi_win_cnt #(
    .BITWIDTH(BITWIDTH)
  ) u_win_cnt (
    .iClk (iClk),
    .iRstN(iRstN),
    .iClr (win_clr),
    .iEn  (win_en),
    .oLast(win_last)
  );

  always_comb begin
    state_d = state_q;
    ones_d  = ones_q;
    data_d  = data_q;
    valid_d = valid_q;
    win_clr = 1'b0;
    win_en  = 1'b0;

    if (iClr) begin
      state_d = StIdle;
      ones_d  = '0;
      valid_d = 1'b0;
      win_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (iEn && iStart) begin
            state_d = StAccum;
            ones_d  = '0;
            win_clr = 1'b1;
          end
        end
        StAccum: begin
          if (iEn) begin
            win_en = 1'b1;
            ones_d = ones_sum;
            if (win_last) begin
              data_d  = ones_sum - Offset;
              valid_d = 1'b1;
              state_d = StDone;
            end
          end
        end
        StDone: begin
          // The handshake completes even while iEn is low; only a restart needs iEn.
          if (valid_q && iReady) begin
            valid_d = 1'b0;
            if (restart) begin
              state_d = StAccum;
              ones_d  = '0;
              win_clr = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= StIdle;
      ones_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ones_q  <= ones_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= (state_d == StAccum);
    end
  end

  assign oBusy  = busy_q;
  assign oValid = valid_q;
  assign oData  = data_q;

endmodule

// File: tb/tb_ubi_stream_acc.sv
// Directed bench for ubi_stream_acc: a BITWIDTH=4 instance for window behaviour and a
// BITWIDTH=8 instance fed by a modelled bipolar multiplier stream.
module tb_ubi_stream_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, clr = 1'b0, ready = 1'b0;
  logic       start4 = 1'b0, bit4 = 1'b0;
  logic       start8 = 1'b0, bit8 = 1'b0;
  logic       busy4, valid4, busy8, valid8;
  logic [4:0] data4;
  logic [8:0] data8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ubi_stream_acc #(.BITWIDTH(4)) dut4 (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start4), .iBit(bit4),
    .iReady(ready), .oBusy(busy4), .oValid(valid4), .oData(data4)
  );

  ubi_stream_acc #(.BITWIDTH(8)) dut8 (
    .iClk(clk), .iRstN(rst_n), .iEn(en), .iClr(clr), .iStart(start8), .iBit(bit8),
    .iReady(ready), .oBusy(busy8), .oValid(valid8), .oData(data8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go4();
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
  endtask

  task automatic hs();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // Feeds 16 samples (pat[0] first); with toggle, each sample is preceded by an iEn-low
  // cycle carrying the inverted bit. bad flags early valid or lost busy mid-window.
  task automatic feed4(input logic [15:0] pat, input bit toggle, output bit bad);
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        en   = 1'b0;
        bit4 = ~pat[i];
        tick();
        if (valid4 || !busy4) bad = 1'b1;
        en = 1'b1;
      end
      bit4 = pat[i];
      tick();
      if (i < 15 && (valid4 || !busy4)) bad = 1'b1;
    end
    bit4 = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({busy4, valid4, data4, busy8, valid8, data8} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%h %b/%b/%h want all zero",
               busy4, valid4, data4, busy8, valid8, data8);
    end
  endtask

  task automatic test_all_ones();
    bit bad;
    go4();
    checks++;
    if ({busy4, valid4} !== 2'b10) begin
      errors++; $display("FAIL start_busy: got busy=%b valid=%b want 1/0", busy4, valid4);
    end
    feed4(16'hFFFF, 1'b0, bad);
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL ones_latency: early valid or busy drop, got %b want 0", bad);
    end
    checks++;
    if ({busy4, valid4, data4} !== {2'b01, 5'b01000}) begin
      errors++;
      $display("FAIL ones_result: got busy=%b valid=%b data=%b want 0/1/01000",
               busy4, valid4, data4);
    end
    hs();
    checks++;
    if ({busy4, valid4, data4} !== {2'b00, 5'b01000}) begin
      errors++;
      $display("FAIL ones_accept: got busy=%b valid=%b data=%b want 0/0/01000",
               busy4, valid4, data4);
    end
  endtask

  task automatic test_zero_alt();
    bit bad;
    go4();
    feed4(16'h0000, 1'b0, bad);
    checks++;
    if ({bad, valid4, data4} !== {2'b01, 5'b11000}) begin
      errors++; $display("FAIL zeros_result: got bad=%b valid=%b data=%b want 0/1/11000",
                         bad, valid4, data4);
    end
    hs();
    go4();
    feed4(16'hAAAA, 1'b0, bad);
    checks++;
    if ({bad, valid4, data4} !== {2'b01, 5'b00000}) begin
      errors++; $display("FAIL alt_result: got bad=%b valid=%b data=%b want 0/1/00000",
                         bad, valid4, data4);
    end
    hs();
  endtask

  task automatic test_en_toggle();
    bit bad;
    go4();
    feed4(16'hFFFF, 1'b1, bad);
    checks++;
    if ({bad, valid4, data4} !== {2'b01, 5'b01000}) begin
      errors++; $display("FAIL en_toggle_result: got bad=%b valid=%b data=%b want 0/1/01000",
                         bad, valid4, data4);
    end
    en = 1'b0;
    tick();
    tick();
    checks++;
    if ({valid4, data4} !== {1'b1, 5'b01000}) begin
      errors++; $display("FAIL en_low_hold: got valid=%b data=%b want 1/01000", valid4, data4);
    end
    hs();
    checks++;
    if ({busy4, valid4} !== 2'b00) begin
      errors++; $display("FAIL en_low_handshake: got busy=%b valid=%b want 0/0", busy4, valid4);
    end
    en = 1'b1;
  endtask

  task automatic test_clear();
    bit bad;
    go4();
    bit4 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bit4 = 1'b0;
    checks++;
    if ({busy4, valid4, data4} !== {2'b00, 5'b01000}) begin
      errors++; $display("FAIL clear_abort: got busy=%b valid=%b data=%b want 0/0/01000",
                         busy4, valid4, data4);
    end
    tick();
    checks++;
    if (busy4 !== 1'b0) begin
      errors++; $display("FAIL clear_idle: got busy=%b want 0", busy4);
    end
    go4();
    feed4(16'h0FFF, 1'b0, bad);
    checks++;
    if ({bad, valid4, data4} !== {2'b01, 5'b00100}) begin
      errors++; $display("FAIL clear_restart: got bad=%b valid=%b data=%b want 0/1/00100",
                         bad, valid4, data4);
    end
    hs();
  endtask

  task automatic test_backpressure();
    bit bad;
    go4();
    feed4(16'h0001, 1'b0, bad);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit4 = i[0];
      tick();
      checks++;
      if ({busy4, valid4, data4} !== {2'b01, 5'b11001}) begin
        errors++; $display("FAIL bp_hold[%0d]: got busy=%b valid=%b data=%b want 0/1/11001",
                           i, busy4, valid4, data4);
      end
    end
    bit4 = 1'b0;
    ready = 1'b1;
    start4 = 1'b1;
    tick();
    ready = 1'b0;
    start4 = 1'b0;
    checks++;
    if ({busy4, valid4} !== 2'b10) begin
      errors++; $display("FAIL b2b_restart: got busy=%b valid=%b want 1/0", busy4, valid4);
    end
    feed4(16'h7FFF, 1'b0, bad);
    checks++;
    if ({bad, valid4, data4} !== {2'b01, 5'b00111}) begin
      errors++; $display("FAIL b2b_result: got bad=%b valid=%b data=%b want 0/1/00111",
                         bad, valid4, data4);
    end
    hs();
  endtask

  task automatic test_umul8();
    int  v;
    bit  a, b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    // A ~ +0.5 (P1=0.75), B ~ -0.5 (P1=0.25), uncorrelated; bipolar product is XNOR.
    for (int i = 0; i < 256; i++) begin
      a = (i % 4) != 0;
      b = ((i / 4) % 4) == 0;
      bit8 = ~(a ^ b);
      tick();
    end
    bit8 = 1'b0;
    v = $signed(data8);
    checks++;
    if (valid8 !== 1'b1 || v < -36 || v > -28) begin
      errors++; $display("FAIL umul_result: got valid=%b data=%0d want 1/-32+-4", valid8, v);
    end
    hs();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bit8 = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    go4();
    checks++;
    if ({busy8, busy4} !== 2'b11) begin
      errors++; $display("FAIL midreset_busy: got %b%b want 11", busy8, busy4);
    end
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    bit8 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy8, valid8, data8} !== 11'd0) begin
      errors++; $display("FAIL post_reset_idle: got busy=%b valid=%b data=%h want 0/0/0",
                         busy8, valid8, data8);
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();
    test_all_ones();
    test_zero_alt();
    test_en_toggle();
    test_clear();
    test_backpressure();
    test_umul8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
